ham84_enc_arbiter: RTL and testbench
====================================

HAM84_ENC_ARBITER -- requirements
Module: ham84_enc_arbiter

Interface
REQ-001 SHALL have parameter: NUM_REQ, 4, number of requesters (2..8).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  NUM_REQ  per-requester nibble valid.
REQ-005 SHALL have port: req_data  input  4*NUM_REQ  nibble of requester i at [4i+3:4i].
REQ-006 SHALL have port: req_ready  output  NUM_REQ  one-hot accept strobe to the granted requester.
REQ-007 SHALL have port: out_valid  output  1  codeword valid.
REQ-008 SHALL have port: out_ready  input  1  downstream accept.
REQ-009 SHALL have port: out_code  output  8  SECDED codeword.
REQ-010 SHALL have port: out_id  output  $clog2(NUM_REQ)  index of the source requester.

Function
REQ-011 SHALL share one internal Hamming(8,4) SECDED encoder among all requesters.
- Nibble bit 3 = d1 ... bit 0 = d4.
- p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4, pg = XOR of d1..d4,p1,p2,p3.
- out_code[7:0] = {p1,p2,d1,p3,d2,d3,d4,pg}.
REQ-012 SHALL implement FSM with states IDLE (no codeword held) and HOLD (codeword held, out_valid=1).
REQ-013 SHALL accept a request when slot free = IDLE, or HOLD with out_ready=1.
- req_ready is combinational: one-hot on the grant winner when the slot is free and any req_valid=1, else all 0.
REQ-014 SHALL register the encoded codeword and winner id at the accept edge.
- out_valid rises the cycle after accept: latency 1 cycle.
- Enter or stay in HOLD.
REQ-015 SHALL go HOLD->IDLE when out_ready=1 and no request is accepted in the same cycle.
- Back-to-back throughput is 1 codeword/cycle.
REQ-016 SHALL keep out_code/out_id stable while out_valid=1 and out_ready=0, regardless of req_* activity.
REQ-017 SHALL arbitrate round-robin.
- Search starts at pointer ptr and increments modulo NUM_REQ.
- After a grant to i, ptr <= (i+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
- ptr is unchanged when there is no grant.
REQ-018 SHALL ignore req_valid bits whose requester is not granted; no data is lost, because that requester keeps its valid asserted.
REQ-019 SHALL drive out_valid=0 in IDLE; out_code/out_id are don't-care then but SHALL hold their last value.

Reset
REQ-020 SHALL on rst_n=0 (asynchronous, any cycle, including mid-HOLD) force:
- state=IDLE, out_valid=0, out_code=8'h00, out_id=0, ptr=0, req_ready=0.
REQ-021 SHALL discard any held codeword on reset; the first grant after reset release goes to the lowest-index valid requester.

Configuration
REQ-022 SHALL support macro HAM84_ARB_ERRINJ_EN.
- When defined: adds inputs inj_en (1) and inj_mask (8).
- On accept with inj_en=1, the registered out_code = encoded ^ inj_mask.
- inj_mask=0 has no effect.
REQ-023 SHALL omit inj_en/inj_mask and all injection logic when HAM84_ARB_ERRINJ_EN is undefined.
- out_code is always the pure encoding.

Verification
REQ-024 Single request: req_valid=4'b0001, nibble 4'b1011, out_ready=1 -> req_ready[0] same cycle; next cycle out_valid=1, out_code=8'h66, out_id=0.
REQ-025 Backpressure: accept nibble 4'b1111, out_ready=0 for 5 cycles, with req_valid[1] asserted throughout -> out_code=8'hFF, out_id stable; req_ready=0 until out_ready=1.
REQ-026 Round-robin: all 4 valid continuously, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, out_valid=1 every cycle.
REQ-027 Wrap/skip: ptr=3, only req 1 valid with nibble 4'b0001 -> grant 1, out_code=8'hD2, next ptr=2.
REQ-028 Reset mid-HOLD: assert rst_n=0 asynchronously while out_valid=1 -> out_valid=0 and out_code=8'h00 before the next clk edge; after release, req 2,3 valid -> grant 2.
REQ-029 With HAM84_ARB_ERRINJ_EN: nibble 4'b0000, inj_en=1, inj_mask=8'h01 -> out_code=8'h01; with inj_en=0 -> 8'h00.

Source files
------------

// File: rtl/ham84_enc_arbiter_if.sv
// Handshake bundle for ham84_enc_arbiter: requester side plus codeword output side.
// Optional error-injection inputs exist only when HAM84_ARB_ERRINJ_EN is defined.
interface ham84_enc_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [4*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_code;
    logic [IdW-1:0]       out_id;
`ifdef HAM84_ARB_ERRINJ_EN
    logic                 inj_en;
    logic [7:0]           inj_mask;

    modport master (
        output req_valid, req_data, out_ready, inj_en, inj_mask,
        input  req_ready, out_valid, out_code, out_id
    );
    modport slave (
        input  req_valid, req_data, out_ready, inj_en, inj_mask,
        output req_ready, out_valid, out_code, out_id
    );
`else
    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_code, out_id
    );
    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_code, out_id
    );
`endif
endinterface

// File: rtl/ham84_enc_arbiter.sv
// Round-robin arbiter feeding one shared Hamming(8,4) SECDED encoder with a one-entry output slot.
// Define HAM84_ARB_ERRINJ_EN to add XOR error injection on the registered codeword.
module ham84_enc_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input logic                clk,
    input logic                rst_n,
    ham84_enc_arbiter_if.slave bus
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e               state_q;
    logic                 out_valid_q;
    logic [7:0]           code_q;
    logic [IdW-1:0]       id_q;
    logic [IdW-1:0]       ptr_q;

    logic                 grant_found;
    logic [IdW-1:0]       grant_idx;
    logic [IdW-1:0]       scan_idx;
    logic [IdW-1:0]       ptr_next;
    logic                 slot_free;
    logic                 accept;
    logic [NUM_REQ-1:0]   ready;
    logic [3:0]           nibble;
    logic [7:0]           code_next;

    // Codeword layout {p1,p2,d1,p3,d2,d3,d4,pg}, nibble bit 3 is d1.
    function automatic logic [7:0] encode(input logic [3:0] n);
        logic d1, d2, d3, d4, p1, p2, p3;
        {d1, d2, d3, d4} = n;
        p1 = d1 ^ d2 ^ d4;
        p2 = d1 ^ d3 ^ d4;
        p3 = d2 ^ d3 ^ d4;
        return {p1, p2, d1, p3, d2, d3, d4, ^{d1, d2, d3, d4, p1, p2, p3}};
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = IdW'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end

        slot_free = !out_valid_q || bus.out_ready;
        // Reset also masks the combinational accept strobe.
        accept    = rst_n && slot_free && grant_found;
        ready     = accept ? (NUM_REQ'(1) << grant_idx) : '0;
        ptr_next  = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + IdW'(1);
        nibble    = bus.req_data[{grant_idx, 2'b00} +: 4];
`ifdef HAM84_ARB_ERRINJ_EN
        code_next = encode(nibble) ^ (bus.inj_en ? bus.inj_mask : 8'h00);
`else
        code_next = encode(nibble);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            code_q      <= 8'h00;
            id_q        <= '0;
            ptr_q       <= '0;
        end else begin
            if (accept) begin
                state_q     <= StHold;
                out_valid_q <= 1'b1;
                code_q      <= code_next;
                id_q        <= grant_idx;
                ptr_q       <= ptr_next;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        out_valid_q <= 1'b0;
                    end
                    StHold: begin
                        if (bus.out_ready) begin
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.req_ready = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_code  = code_q;
    assign bus.out_id    = id_q;
endmodule

// File: tb/tb_ham84_enc_arbiter.sv
// Self-checking bench for ham84_enc_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model.
module tb_ham84_enc_arbiter;
    localparam int unsigned N = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   run_cmp  = 1'b0;

    ham84_enc_arbiter_if #(.NUM_REQ(N)) bus ();

    ham84_enc_arbiter #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hamming positions 1..7; parity at powers of two covers every position sharing its bit.
    function automatic logic [7:0] m_enc(input logic [3:0] n);
        logic [7:1] cw;
        cw    = '0;
        cw[3] = n[3];
        cw[5] = n[2];
        cw[6] = n[1];
        cw[7] = n[0];
        for (int p = 1; p <= 4; p = p * 2)
            for (int j = 3; j <= 7; j++)
                if ((j & p) != 0 && j != p) cw[p] = cw[p] ^ cw[j];
        return {cw[1], cw[2], cw[3], cw[4], cw[5], cw[6], cw[7], ^cw};
    endfunction

    function automatic int m_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < int'(N); k++) begin
            int i;
            i = (p + k) % int'(N);
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_inj();
`ifdef HAM84_ARB_ERRINJ_EN
        return bus.inj_en ? bus.inj_mask : 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    // Behavioural model state
    logic         m_valid;
    logic [7:0]   m_code;
    logic [1:0]   m_id;
    int           m_ptr;
    int           m_g;
    logic         m_acc;
    logic [N-1:0] exp_ready;

    always_comb begin
        m_g       = m_pick(bus.req_valid, m_ptr);
        m_acc     = rst_n && (m_g >= 0) && (!m_valid || bus.out_ready);
        exp_ready = m_acc ? (N'(1) << m_g) : '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_code  <= 8'h00;
            m_id    <= 2'd0;
            m_ptr   <= 0;
        end else if (m_acc) begin
            m_valid <= 1'b1;
            m_code  <= m_enc(4'(bus.req_data >> (4 * m_g))) ^ m_inj();
            m_id    <= 2'(m_g);
            m_ptr   <= (m_g + 1) % int'(N);
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && run_cmp) begin
            chk("m_req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("m_out_code", 32'(bus.out_code), 32'(m_code));
            chk("m_out_id", 32'(bus.out_id), 32'(m_id));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = 16'h5A3C;
        bus.out_ready = 1'b1;
`ifdef HAM84_ARB_ERRINJ_EN
        bus.inj_en    = 1'b0;
        bus.inj_mask  = 8'h00;
`endif
        chk("model_enc_b", 32'(m_enc(4'b1011)), 32'h66);
        chk("model_enc_f", 32'(m_enc(4'b1111)), 32'hFF);
        chk("model_enc_1", 32'(m_enc(4'b0001)), 32'hD2);

        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_code", 32'(bus.out_code), 32'h00);
        chk("rst_out_id", 32'(bus.out_id), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        step();
        step();
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_cmp = 1'b1;

        // Single request
        bus.req_valid = 4'b0001;
        bus.req_data  = 16'h000B;
        @(negedge clk);
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        step();
        bus.req_valid = '0;
        chk("single_valid", 32'(bus.out_valid), 32'h1);
        chk("single_code", 32'(bus.out_code), 32'h66);
        chk("single_id", 32'(bus.out_id), 32'h0);
        step();
        chk("single_drain", 32'(bus.out_valid), 32'h0);

        // Backpressure with requester 1 waiting (ptr is 1, only req 0 valid -> grant 0)
        bus.req_valid = 4'b0001;
        bus.req_data  = 16'h000F;
        step();
        bus.req_valid = 4'b0010;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_valid", 32'(bus.out_valid), 32'h1);
            chk("bp_code", 32'(bus.out_code), 32'hFF);
            chk("bp_id", 32'(bus.out_id), 32'h0);
            step();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = '0;
        chk("bp_next_id", 32'(bus.out_id), 32'h1);
        chk("bp_next_code", 32'(bus.out_code), 32'h00);
        step();

        // Round-robin from a fresh reset
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_ready", 32'(bus.req_ready), 32'(4'b0001 << (i % 4)));
            if (i > 0) chk("rr_valid", 32'(bus.out_valid), 32'h1);
            step();
        end
        chk("rr_last_id", 32'(bus.out_id), 32'h0);

        // Wrap/skip: move ptr to 3, then only requester 1 valid
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b0010;
        bus.req_data  = 16'h0010;
        @(negedge clk);
        chk("wrap_ready", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = 4'b1111;
        chk("wrap_code", 32'(bus.out_code), 32'hD2);
        chk("wrap_id", 32'(bus.out_id), 32'h1);
        @(negedge clk);
        chk("wrap_ptr", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        step();

        // Asynchronous reset while holding
        bus.req_valid = 4'b0001;
        bus.req_data  = 16'h0007;
        step();
        bus.req_valid = 4'b1100;
        bus.out_ready = 1'b0;
        chk("mid_hold_valid", 32'(bus.out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.out_valid), 32'h0);
        chk("async_code", 32'(bus.out_code), 32'h00);
        chk("async_id", 32'(bus.out_id), 32'h0);
        chk("async_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'h4);
        step();
        bus.req_valid = '0;
        step();

`ifdef HAM84_ARB_ERRINJ_EN
        bus.req_valid = 4'b0001;
        bus.req_data  = 16'h0000;
        bus.inj_en    = 1'b1;
        bus.inj_mask  = 8'h01;
        step();
        chk("inj_on", 32'(bus.out_code), 32'h01);
        bus.req_valid = 4'b0010;
        bus.inj_en    = 1'b0;
        step();
        chk("inj_off", 32'(bus.out_code), 32'h00);
        bus.req_valid = '0;
        step();
`endif

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            bus.req_valid = N'($urandom);
            bus.req_data  = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef HAM84_ARB_ERRINJ_EN
            bus.inj_en    = ($urandom_range(0, 3) == 0);
            bus.inj_mask  = 8'($urandom);
`endif
            step();
        end

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
